// File: rtl/sar_search_ctrl_if.sv
// Operand-side bundle between a requester/comparator and the SAR search controller.
// No storage; pure signal grouping with direction views for each side.
// No backpressure: start is a level request, done is a single-cycle pulse.
interface sar_search_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic [WIDTH-1:0] probe;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    // Requester + comparator side: issues start, answers probes with flags.
    modport master (
        output start, a_gt_b, a_lt_b, a_eq_b,
        input  probe, busy, done, result, err
    );

    // Controller side.
    modport slave (
        input  start, a_gt_b, a_lt_b, a_eq_b,
        output probe, busy, done, result, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// MSB-first successive-approximation search recovering the comparator A operand via probe/flags.
// Latency: WIDTH*(CMP_WAIT+1)+1 cycles start->done; shorter with SAR_EARLY_EXIT_EN on an exact match.
// No backpressure: start is only accepted in IDLE and ignored otherwise; done pulses one cycle.
module sar_search_ctrl #(
    parameter int WIDTH    = 4,
    parameter int CMP_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sar_search_ctrl_if.slave  bus
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] next_mask;
    logic [WIDTH-1:0] acc_new;
    logic             flags_onehot;
    logic             eq_hit;

    // Decision for the bit under trial: a_lt_b means the probe overshot, so the bit stays 0.
    always_comb begin
        bit_mask      = '0;
        bit_mask[idx] = 1'b1;
        next_mask     = bit_mask >> 1;
        acc_new       = bus.a_lt_b ? acc : (acc | bit_mask);
        flags_onehot  = $onehot({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b});
        eq_hit        = EARLY_EXIT && flags_onehot && bus.a_eq_b;
    end

    // Search FSM; all handshake outputs and the probe are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            acc        <= '0;
            bus.probe  <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.err    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx       <= IW'(WIDTH - 1);
                        acc       <= '0;
                        bus.probe <= {1'b1, {(WIDTH-1){1'b0}}};
                        cnt       <= 4'(CMP_WAIT);
                        bus.err   <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Malformed flags are flagged but never alter the decision path.
                        if (!flags_onehot) begin
                            bus.err <= 1'b1;
                        end
                        if (eq_hit) begin
                            bus.result <= bus.probe;
                            state      <= DONE;
                        end else if (idx != '0) begin
                            idx       <= idx - 1'b1;
                            acc       <= acc_new;
                            bus.probe <= acc_new | next_mask;
                            cnt       <= 4'(CMP_WAIT);
                        end else begin
                            acc        <= acc_new;
                            bus.result <= acc_new;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.done  <= 1'b1;
                    bus.busy  <= 1'b0;
                    bus.probe <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench: behavioural comparator + closed-form SAR probe model.
// Two instances: CMP_WAIT=1 for directed/random/reset/fault runs, CMP_WAIT=0 for back-to-back starts.
// Outputs are sampled at the falling edge; inputs change at the falling edge or #1 after the rising edge.
module tb_sar_search_ctrl;

    localparam int W  = 4;
    localparam int CW = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [W-1:0] tgt;
    logic [W-1:0] tgt0;
    logic flt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sar_search_ctrl_if #(.WIDTH(W)) bus ();
    sar_search_ctrl_if #(.WIDTH(W)) bus0 ();

    // Comparator models: flags are combinational in the probe; flt forces an illegal gt+lt pair.
    assign bus.a_gt_b  = flt ? 1'b1 : (tgt > bus.probe);
    assign bus.a_lt_b  = flt ? 1'b1 : (tgt < bus.probe);
    assign bus.a_eq_b  = (tgt == bus.probe);
    assign bus0.a_gt_b = (tgt0 > bus0.probe);
    assign bus0.a_lt_b = (tgt0 < bus0.probe);
    assign bus0.a_eq_b = (tgt0 == bus0.probe);

    sar_search_ctrl #(.WIDTH(W), .CMP_WAIT(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sar_search_ctrl #(.WIDTH(W), .CMP_WAIT(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Probe at step j of a binary search for t: t's bits above the trial bit, plus the trial bit.
    function automatic logic [W-1:0] prefix(input logic [W-1:0] t, input int j);
        int b;
        int v;
        b = W - 1 - j;
        v = (int'(t) / (2 ** (b + 1))) * (2 ** (b + 1)) + (2 ** b);
        return v[W-1:0];
    endfunction

    // Number of probes issued before the search ends.
    function automatic int n_steps(input logic [W-1:0] t);
`ifdef SAR_EARLY_EXIT_EN
        for (int j = 0; j < W; j++) begin
            if (prefix(t, j) == t) return j + 1;
        end
`endif
        return W;
    endfunction

    // One complete search on the CMP_WAIT=CW instance; fault_step<0 means clean flags throughout.
    task automatic run_search(input logic [W-1:0] t, input int fault_step, input string tag);
        int steps;
        logic exp_err;
        steps   = n_steps(t);
        exp_err = (fault_step >= 0) && (fault_step < steps);
        tgt     = t;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int j = 0; j < steps; j++) begin
            for (int h = 0; h <= CW; h++) begin
                @(negedge clk);
                chk({tag, ".probe"}, 32'(bus.probe), 32'(prefix(t, j)));
                chk({tag, ".busy"},  32'(bus.busy), 32'd1);
                chk({tag, ".done_early"}, 32'(bus.done), 32'd0);
                if (j == 0 && h == 0) chk({tag, ".err_cleared"}, 32'(bus.err), 32'd0);
                if (h == CW && j == fault_step) flt = 1'b1;
                @(posedge clk);
                #1 flt = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, ".done_last_busy"}, 32'(bus.done), 32'd0);
        @(negedge clk);
        chk({tag, ".done"},   32'(bus.done),   32'd1);
        chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, ".probe_at_done"}, 32'(bus.probe), 32'd0);
        chk({tag, ".result"}, 32'(bus.result), 32'(t));
        chk({tag, ".err"},    32'(bus.err),    32'(exp_err));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] t;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus0.start = 1'b0;
        flt        = 1'b0;
        tgt        = '0;
        tgt0       = 4'd6;
        #12;
        chk("rst.probe",  32'(bus.probe),  32'd0);
        chk("rst.busy",   32'(bus.busy),   32'd0);
        chk("rst.done",   32'(bus.done),   32'd0);
        chk("rst.result", 32'(bus.result), 32'd0);
        chk("rst.err",    32'(bus.err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner targets.
        run_search(4'd9,  -1, "t9");
        run_search(4'd0,  -1, "t0");
        run_search(4'd15, -1, "t15");
        run_search(4'd8,  -1, "t8");
        run_search(4'd3,  -1, "t3");

        // Reset asserted while the second probe is on the bus.
        t   = 4'($urandom_range(1, 15));
        tgt = t;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (CW + 1) @(posedge clk);
        @(negedge clk);
        chk("midrst.probe_before", 32'(bus.probe), 32'(prefix(t, 1)));
        rst_n = 1'b0;
        #1;
        chk("midrst.probe",  32'(bus.probe),  32'd0);
        chk("midrst.busy",   32'(bus.busy),   32'd0);
        chk("midrst.done",   32'(bus.done),   32'd0);
        chk("midrst.result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_search(t, -1, "after_rst");

        // Illegal flag set at the third sample; err must stay set while idle.
        run_search(4'd5, 2, "fault5");
        repeat (3) @(negedge clk);
        chk("fault5.err_sticky", 32'(bus.err), 32'd1);
        run_search(4'($urandom_range(0, 15)), -1, "clear_err");

        // Randomized targets.
        for (int n = 0; n < 8; n++) begin
            run_search(4'($urandom_range(0, 15)), -1, "rand");
        end

        // Continuous start on the CMP_WAIT=0 instance: done every 6 cycles, never re-accepted while busy.
        @(negedge clk);
        bus0.start = 1'b1;
        for (int e = 0; e < 24; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hs.done", 32'(bus0.done), 32'((e % 6) == 5));
            chk("hs.busy", 32'(bus0.busy), 32'((e % 6) != 5));
            if ((e % 6) == 5) begin
                chk("hs.result", 32'(bus0.result), 32'd6);
                chk("hs.err",    32'(bus0.err),    32'd0);
            end
        end
        bus0.start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
